// File: rtl/rs_chien_sweep_gen.sv
// -----------------------------------------------------------------------------
// gf_pkg / rs_chien_sweep_gen
//
// Purpose
//   Chien-search root sequencer. A single accepted start pulse sweeps every
//   evaluation exponent of one codeword: FIRST_POW .. FIRST_POW+N_LEN-1 (mod Q).
//   Each beat carries ROOTS_PER_CYCLE lanes of (exponent, alpha^exponent).
//   Lanes past the end of a shortened code are masked and driven to zero.
//
// Ports
//   aclk          in   rising-edge clock
//   aresetn       in   asynchronous active-low reset
//   start         in   request a new sweep (accepted when start && start_rdy)
//   start_rdy     out  IDLE, or the last beat is transferring this cycle
//   flush         in   synchronous abort; wins over start and any transfer
//   out_vld       out  beat valid
//   out_rdy       in   downstream accepts the beat
//   out_exp[R]    out  lane exponent (0 for masked lanes)
//   out_root[R]   out  alpha^out_exp (0 for masked lanes)
//   out_lane_vld  out  bit i set when lane i holds a real root
//   out_beat      out  beat index 0..BEATS-1
//   out_last      out  final beat of the sweep
// -----------------------------------------------------------------------------
package gf_pkg;
   localparam int SYMB_WIDTH = 8;
   // Low bits of the primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
   localparam logic [SYMB_WIDTH-1:0] PRIM_POLY_LO = 8'h1D;
endpackage

module rs_chien_sweep_gen #(
   parameter  int N_LEN           = 255,
   parameter  int ROOTS_PER_CYCLE = 4,
   parameter  int FIRST_POW       = 0,
   localparam int SW              = gf_pkg::SYMB_WIDTH,
   localparam int BEATS           = (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE,
   localparam int CW              = ($clog2(BEATS) > 0) ? $clog2(BEATS) : 1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       start,
   output logic                       start_rdy,
   input  logic                       flush,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [SW-1:0]              out_exp  [ROOTS_PER_CYCLE],
   output logic [SW-1:0]              out_root [ROOTS_PER_CYCLE],
   output logic [ROOTS_PER_CYCLE-1:0] out_lane_vld,
   output logic [CW-1:0]              out_beat,
   output logic                       out_last
);

   localparam int R          = ROOTS_PER_CYCLE;
   localparam int Q          = (1 << SW) - 1;
   localparam int LAST_LANES = N_LEN - (BEATS - 1) * R;

   // GF(2^SW) helpers; all uses are either constant-folded or a
   // multiply by a constant, so they reduce to small XOR networks.
   function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] v);
      return {v[SW-2:0], 1'b0} ^ (v[SW-1] ? gf_pkg::PRIM_POLY_LO : '0);
   endfunction

   function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic [SW-1:0] p;
      p = '0;
      for (int k = SW - 1; k >= 0; k--) begin
         p = gf_xtime(p);
         if (b[k]) p = p ^ a;
      end
      return p;
   endfunction

   function automatic logic [SW-1:0] alpha_pow(input int e);
      logic [SW-1:0] v;
      v = SW'(1);
      for (int k = 0; k < Q; k++) begin
         if (k < e) v = gf_xtime(v);
      end
      return v;
   endfunction

   localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
   localparam logic [SW:0]   Q_EXT      = (SW + 1)'(Q);
   localparam logic [SW:0]   STEP_EXP   = (SW + 1)'(R % Q);
   localparam logic [SW-1:0] FIRST_EXP  = SW'(FIRST_POW);
   localparam logic [SW-1:0] FIRST_ROOT = alpha_pow(FIRST_POW);
   localparam logic [SW-1:0] ALPHA_R    = alpha_pow(R % Q);

   if (R < 1 || R > N_LEN || N_LEN > Q || FIRST_POW < 0 || FIRST_POW >= Q) begin : g_bad_cfg
      $error("rs_chien_sweep_gen: need 1 <= ROOTS_PER_CYCLE <= N_LEN <= 2^SW-1 and FIRST_POW < 2^SW-1");
   end

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_xfer;
   logic            w_load_first;
   logic            w_advance;
   logic            w_clear;

   logic [CW-1:0]   r_beat;
   logic            r_last;
   logic [SW-1:0]   r_base_exp;
   logic [SW-1:0]   r_base_root;
   logic [SW-1:0]   r_exp  [R];
   logic [SW-1:0]   r_root [R];
   logic [R-1:0]    r_lane_vld;

   logic [CW-1:0]   w_nxt_beat;
   logic [SW-1:0]   w_nxt_base_exp;
   logic [SW-1:0]   w_nxt_base_root;
   logic [SW:0]     w_base_sum;
   logic [SW-1:0]   w_lane_exp  [R];
   logic [SW-1:0]   w_lane_root [R];
   logic [R-1:0]    w_lane_vld;

   // ---- control: state register ----
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ---- control: next state and load strobes ----
   always_comb begin
      w_state_nxt  = r_state;
      w_load_first = 1'b0;
      w_advance    = 1'b0;
      w_clear      = 1'b0;
      w_xfer       = (r_state == ST_RUN) && out_rdy;
      start_rdy    = (r_state == ST_IDLE) || (w_xfer && r_last);

      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_clear     = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt  = ST_RUN;
                  w_load_first = 1'b1;
               end
            end
            ST_RUN: begin
               if (w_xfer) begin
                  if (!r_last) begin
                     w_advance = 1'b1;
                  end else if (start) begin
                     // Back-to-back: beat 0 of the next sweep follows with no bubble.
                     w_load_first = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_clear     = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_clear     = 1'b1;
            end
         endcase
      end
   end

   // ---- datapath: next beat base (exponent mod Q and matching alpha power) ----
   always_comb begin
      w_base_sum = {1'b0, r_base_exp} + STEP_EXP;
      if (w_base_sum >= Q_EXT) w_base_sum = w_base_sum - Q_EXT;
   end

   assign w_nxt_beat      = w_load_first ? '0         : r_beat + CW'(1);
   assign w_nxt_base_exp  = w_load_first ? FIRST_EXP  : w_base_sum[SW-1:0];
   assign w_nxt_base_root = w_load_first ? FIRST_ROOT : gf_mul(r_base_root, ALPHA_R);

   // ---- datapath: per-lane offset, wrap and mask ----
   for (genvar i = 0; i < R; i++) begin : g_lane
      localparam logic [SW:0]   LANE_OFF   = (SW + 1)'(i);
      localparam logic [SW-1:0] LANE_ALPHA = alpha_pow(i);
      localparam bit            IN_LAST    = (i < LAST_LANES);
      logic [SW:0] w_sum;

      // base < Q and i < Q, so one conditional subtract keeps the result in 0..Q-1.
      always_comb begin
         w_sum = {1'b0, w_nxt_base_exp} + LANE_OFF;
         if (w_sum >= Q_EXT) w_sum = w_sum - Q_EXT;
      end

      // Only the final beat can be partial.
      assign w_lane_vld[i]  = (w_nxt_beat != LAST_BEAT) || IN_LAST;
      assign w_lane_exp[i]  = w_lane_vld[i] ? w_sum[SW-1:0] : '0;
      assign w_lane_root[i] = w_lane_vld[i] ? gf_mul(w_nxt_base_root, LANE_ALPHA) : '0;
   end

   // ---- datapath: registered beat ----
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_beat      <= '0;
         r_last      <= 1'b0;
         r_base_exp  <= '0;
         r_base_root <= '0;
         r_lane_vld  <= '0;
         r_exp       <= '{default: '0};
         r_root      <= '{default: '0};
      end else if (w_clear) begin
         r_beat      <= '0;
         r_last      <= 1'b0;
         r_base_exp  <= '0;
         r_base_root <= '0;
         r_lane_vld  <= '0;
         r_exp       <= '{default: '0};
         r_root      <= '{default: '0};
      end else if (w_load_first || w_advance) begin
         r_beat      <= w_nxt_beat;
         r_last      <= (w_nxt_beat == LAST_BEAT);
         r_base_exp  <= w_nxt_base_exp;
         r_base_root <= w_nxt_base_root;
         r_lane_vld  <= w_lane_vld;
         r_exp       <= w_lane_exp;
         r_root      <= w_lane_root;
      end
   end

   assign out_vld      = (r_state == ST_RUN);
   assign out_exp      = r_exp;
   assign out_root     = r_root;
   assign out_lane_vld = r_lane_vld;
   assign out_beat     = r_beat;
   assign out_last     = r_last;

endmodule

// File: tb/tb_rs_chien_sweep_gen.sv
module tb_rs_chien_sweep_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] exp;
      logic [63:0] root;
      logic [7:0]  msk;
      int          beat;
      bit          last;
   } beat_t;

   // alpha^e in GF(2^8) with polynomial 0x11D, by repeated doubling.
   function automatic int gf_alog(input int e);
      int v;
      v = 1;
      for (int k = 0; k < e; k++) begin
         v = v << 1;
         if ((v & 256) != 0) v = v ^ 'h11D;
      end
      return v;
   endfunction

   function automatic void chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL cfg%0d %s got %0h want %0h", cfg, nm, act, want);
      end
   endfunction

   // cfg0: R=4 N=255 F=0 | cfg1: R=4 N=255 F=250 | cfg2: R=8 N=20 F=0 | cfg3: R=7 N=7 F=254
   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int N     = (g == 2) ? 20 : (g == 3) ? 7 : 255;
      localparam int R     = (g == 2) ? 8 : (g == 3) ? 7 : 4;
      localparam int F     = (g == 1) ? 250 : (g == 3) ? 254 : 0;
      localparam int Q     = 255;
      localparam int BEATS = (N + R - 1) / R;
      localparam int CW    = ($clog2(BEATS) > 0) ? $clog2(BEATS) : 1;
      localparam int FLUSH_AT = (BEATS - 1 < 10) ? BEATS - 1 : 10;

      logic          aresetn, start, flush, out_rdy;
      logic          start_rdy, out_vld, out_last;
      logic [7:0]    out_exp  [R];
      logic [7:0]    out_root [R];
      logic [R-1:0]  out_lane_vld;
      logic [CW-1:0] out_beat;

      beat_t q[$];
      bit    chk_zero = 1'b0;
      bit    done = 1'b0;
      int    acc = 0;

      rs_chien_sweep_gen #(
         .N_LEN(N), .ROOTS_PER_CYCLE(R), .FIRST_POW(F)
      ) dut (
         .aclk(clk), .aresetn(aresetn), .start(start), .start_rdy(start_rdy),
         .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
         .out_exp(out_exp), .out_root(out_root), .out_lane_vld(out_lane_vld),
         .out_beat(out_beat), .out_last(out_last)
      );

      // Reference: every root of the sweep as exponent list sliced into beats.
      function automatic void push_sweep();
         beat_t e;
         for (int b = 0; b < BEATS; b++) begin
            e.exp = '0; e.root = '0; e.msk = '0;
            e.beat = b;
            e.last = (b == BEATS - 1);
            for (int i = 0; i < R; i++) begin
               if (b * R + i < N) begin
                  e.exp[i*8 +: 8]  = 8'((F + b * R + i) % Q);
                  e.root[i*8 +: 8] = 8'(gf_alog((F + b * R + i) % Q));
                  e.msk[i]         = 1'b1;
               end
            end
            q.push_back(e);
         end
      endfunction

      // Monitor / scoreboard
      always @(negedge clk) begin
         logic [63:0] a_exp, a_root;
         beat_t e;
         a_exp = '0; a_root = '0;
         for (int i = 0; i < R; i++) begin
            a_exp[i*8 +: 8]  = out_exp[i];
            a_root[i*8 +: 8] = out_root[i];
         end
         if (!aresetn) begin
            chk(g, "rst_vld", 64'(out_vld), 64'd0);
            chk(g, "rst_start_rdy", 64'(start_rdy), 64'd1);
            chk(g, "rst_last", 64'(out_last), 64'd0);
            chk(g, "rst_beat", 64'(out_beat), 64'd0);
            chk(g, "rst_mask", 64'(out_lane_vld), 64'd0);
            chk(g, "rst_exp", a_exp, 64'd0);
            chk(g, "rst_root", a_root, 64'd0);
            q.delete();
            chk_zero = 1'b0;
         end else begin
            chk(g, "vld", 64'(out_vld), 64'(q.size() != 0));
            chk(g, "start_rdy", 64'(start_rdy), 64'((q.size() == 0) || (out_rdy && q.size() == 1)));
            if (chk_zero) begin
               chk(g, "flush_mask", 64'(out_lane_vld), 64'd0);
               chk(g, "flush_exp", a_exp, 64'd0);
               chk(g, "flush_root", a_root, 64'd0);
               chk(g, "flush_beat", 64'(out_beat), 64'd0);
               chk(g, "flush_last", 64'(out_last), 64'd0);
               chk_zero = 1'b0;
            end
            if (q.size() != 0) begin
               e = q[0];
               chk(g, "exp", a_exp, e.exp);
               chk(g, "root", a_root, e.root);
               chk(g, "mask", 64'(out_lane_vld), 64'(e.msk));
               chk(g, "beat", 64'(out_beat), 64'(e.beat));
               chk(g, "last", 64'(out_last), 64'(e.last));
               if (flush) begin
                  q.delete();
                  chk_zero = 1'b1;
               end else if (out_rdy) begin
                  void'(q.pop_front());
               end
            end else if (flush) begin
               chk_zero = 1'b1;
            end
         end
      end

      // One clock: acceptance is judged mid-cycle, inputs change just after the edge.
      task automatic tick();
         @(negedge clk);
         #1;
         if (aresetn && start && start_rdy && !flush) begin
            push_sweep();
            acc++;
         end
         @(posedge clk);
         #1;
      endtask

      task automatic wait_idle(input int limit);
         int n;
         n = 0;
         while (q.size() != 0 && n < limit) begin
            tick();
            n++;
         end
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL cfg%0d sweep_timeout got %0d beats left want 0", g, q.size());
            q.delete();
         end
      endtask

      initial begin
         aresetn = 1'b0; start = 1'b0; flush = 1'b0; out_rdy = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         aresetn = 1'b1;

         // Full sweep, with a start attempt while beat 5 is presented.
         start = 1'b1; tick(); start = 1'b0;
         repeat (5) tick();
         start = 1'b1; tick(); start = 1'b0;
         wait_idle(2000);

         // Random backpressure.
         start = 1'b1; tick(); start = 1'b0;
         for (int n = 0; n < 3000 && q.size() != 0; n++) begin
            out_rdy = 1'($urandom_range(0, 1));
            tick();
         end
         out_rdy = 1'b1;
         wait_idle(200);

         // start held through the last transfer: two sweeps back-to-back.
         acc = 0;
         start = 1'b1;
         for (int n = 0; n < 2000 && acc < 2; n++) tick();
         start = 1'b0;
         chk(g, "b2b_accepts", 64'(acc), 64'd2);
         wait_idle(2000);

         // Flush together with start mid-sweep, then a fresh sweep.
         start = 1'b1; tick(); start = 1'b0;
         repeat (FLUSH_AT) tick();
         flush = 1'b1; start = 1'b1; tick();
         flush = 1'b0; start = 1'b0;
         chk(g, "flush_vld", 64'(out_vld), 64'd0);
         tick();
         start = 1'b1; tick(); start = 1'b0;
         wait_idle(2000);

         // Asynchronous reset mid-sweep, then a fresh sweep.
         start = 1'b1; tick(); start = 1'b0;
         repeat (3) tick();
         aresetn = 1'b0; tick();
         aresetn = 1'b1; tick();
         chk(g, "post_rst_vld", 64'(out_vld), 64'd0);
         start = 1'b1; tick(); start = 1'b0;
         wait_idle(2000);

         done = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)) begin
         errors++;
         $display("FAIL global_timeout got %0d cycles want completion", n);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
